ccg_response_misr: RTL

//  Downstream capture stage for the CCGRCG combinational benchmark netlists.
//  - Accepts one OUT_W-bit response word (f1..f28 packed, f1 = bit 0) per handshake.
//  - Compacts a run of num_vec responses into a SIG_W-bit MISR signature.
//  - Compares the final signature against a golden value and reports pass/fail.
//  - Sits between the netlist under test and the dataset-labelling / checker logic.

---
 rtl/ccg_response_misr.sv | 111 +++++++++++
 1 files changed

// File: rtl/ccg_response_misr.sv
// Response capture stage: compacts benchmark output words into a MISR
// signature and compares the final value against a golden signature.
module ccg_response_misr #(
   parameter int unsigned         OUT_W = 28,
   parameter int unsigned         SIG_W = 32,
   parameter logic [SIG_W-1:0]    POLY  = 32'h04C11DB7,
   parameter logic [SIG_W-1:0]    SEED  = 32'h00000000,
   parameter int unsigned         CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] num_vec,
   input  logic [SIG_W-1:0] golden,
   input  logic             resp_valid,
   input  logic [OUT_W-1:0] resp_data,
   output logic             resp_ready,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [SIG_W-1:0] signature,
   output logic [CNT_W-1:0] vec_count
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_CHECK = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [SIG_W-1:0] sig_q, sig_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] num_q, num_d;
   logic [SIG_W-1:0] gold_q, gold_d;
   logic             pass_q, pass_d;

   logic             xfer;
   logic             start_ok;
   logic [CNT_W-1:0] cnt_inc;
   logic [SIG_W-1:0] sig_next;

   assign xfer     = (state_q == S_RUN) && resp_valid;
   assign start_ok = start && ((state_q == S_IDLE) || (state_q == S_DONE));
   assign cnt_inc  = cnt_q + CNT_W'(1);
   assign sig_next = {sig_q[SIG_W-2:0], 1'b0}
                   ^ (sig_q[SIG_W-1] ? POLY : '0)
                   ^ SIG_W'(resp_data);

   always_comb begin
      state_d = state_q;
      sig_d   = sig_q;
      cnt_d   = cnt_q;
      num_d   = num_q;
      gold_d  = gold_q;
      pass_d  = pass_q;
      // abort outranks start and drops any same-cycle word
      if (abort) begin
         state_d = S_IDLE;
         pass_d  = 1'b0;
      end else if (start_ok) begin
         num_d   = num_vec;
         gold_d  = golden;
         sig_d   = SEED;
         cnt_d   = '0;
         pass_d  = 1'b0;
         state_d = (num_vec == '0) ? S_CHECK : S_RUN;
      end else begin
         case (state_q)
            S_RUN: begin
               if (xfer) begin
                  sig_d = sig_next;
                  cnt_d = cnt_inc;
                  if (cnt_inc == num_q) state_d = S_CHECK;
               end
            end
            S_CHECK: begin
               pass_d  = (sig_q == gold_q);
               state_d = S_DONE;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         sig_q   <= SEED;
         cnt_q   <= '0;
         num_q   <= '0;
         gold_q  <= '0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sig_q   <= sig_d;
         cnt_q   <= cnt_d;
         num_q   <= num_d;
         gold_q  <= gold_d;
         pass_q  <= pass_d;
      end
   end

   assign resp_ready = (state_q == S_RUN);
   assign busy       = (state_q == S_RUN) || (state_q == S_CHECK);
   assign done       = (state_q == S_DONE);
   assign pass       = done & pass_q;
   assign signature  = sig_q;
   assign vec_count  = cnt_q;

endmodule
